// File: rtl/ula_32_if.sv
// ula_32_if: operand/result bundle between the MIPS execute stage and ula_32.
// Overflow exists only when ULA32_OVF_EN is defined.
interface ula_32_if;
    logic [3:0]  ULAControl;
    logic [31:0] scrA;
    logic [31:0] scrB;
    logic [31:0] ULAResult;
    logic        Zero;
`ifdef ULA32_OVF_EN
    logic        Overflow;
`endif

    // Datapath side: drives the operation, consumes the registered result.
    modport master (
        output ULAControl,
        output scrA,
        output scrB,
        input  ULAResult,
`ifdef ULA32_OVF_EN
        input  Overflow,
`endif
        input  Zero
    );

    // ALU side: consumes the operation, drives the registered result.
    modport slave (
        input  ULAControl,
        input  scrA,
        input  scrB,
        output ULAResult,
`ifdef ULA32_OVF_EN
        output Overflow,
`endif
        output Zero
    );
endinterface

// File: rtl/ula_32.sv
// ula_32: 32-bit MIPS ALU with a one-cycle registered result and zero flag.
// Optional signed-overflow flag for ADD/SUB enabled by defining ULA32_OVF_EN.
module ula_32 (
    input  logic     clk,
    input  logic     rst_n,
    ula_32_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SUB2 = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SLE  = 4'b0110,
        OP_SLD  = 4'b0111,
        OP_SAD  = 4'b1000
    } ula_op_e;

    ula_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        zero_d;
    logic        zero_q;

    assign op    = ula_op_e'(bus.ULAControl);
    assign a     = bus.scrA;
    assign b     = bus.scrB;
    // Only the low five bits select a shift distance; the rest of B is ignored.
    assign shamt = b[4:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // Select the next result; unused opcodes 1001-1111 yield zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves result_d unassigned (no latch).
        result_d = 32'h0000_0000;
        unique case (op)
            OP_ADD:          result_d = sum;
            OP_SUB, OP_SUB2: result_d = diff;
            OP_AND:          result_d = a & b;
            OP_OR:           result_d = a | b;
            OP_XOR:          result_d = a ^ b;
            OP_SLE:          result_d = a << shamt;
            OP_SLD:          result_d = a >> shamt;
            OP_SAD:          result_d = $unsigned($signed(a) >>> shamt);
            default:         result_d = 32'h0000_0000;
        endcase
    end

    // Zero is derived from the value being registered, not from the old register.
    assign zero_d = (result_d == 32'h0000_0000);

    // Output register for result and zero flag; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (!rst_n) begin
            result_q <= 32'h0000_0000;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ULAResult = result_q;
    assign bus.Zero      = zero_q;

`ifdef ULA32_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: ADD when operand signs agree and the result sign differs;
    // SUB when operand signs differ and the result sign differs from A.
    always_comb begin
        ovf_d = 1'b0;
        unique case (op)
            OP_ADD:          ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
            OP_SUB, OP_SUB2: ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
            default:         ovf_d = 1'b0;
        endcase
    end

    // Overflow is registered alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_ula_32.sv
// tb_ula_32: scoreboard bench for ula_32. Stimulus pushes expected responses
// from an arithmetic reference model; a monitor pops one per cycle and compares.
// Overflow is checked when ULA32_OVF_EN is defined.
module tb_ula_32;

    logic clk;
    logic rst_n;

    ula_32_if bus ();

    ula_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam longint unsigned MOD32 = 64'h1_0000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on mathematical values.
    function automatic exp_t model(input logic rst, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input string tag);
        exp_t e;
        longint unsigned ua  = {32'h0, a};
        longint unsigned ub  = {32'h0, b};
        longint          sa  = longint'($signed(a));
        longint          sb  = longint'($signed(b));
        longint unsigned pw  = 64'd1 << (b % 32);
        longint unsigned r   = 0;
        longint          sr  = 0;
        logic            ovf = 1'b0;
        if (!rst) begin
            e.res = 32'h0; e.zero = 1'b1; e.ovf = 1'b0; e.tag = {tag, "/rst"};
            return e;
        end
        case (op)
            4'd0: begin
                r   = (ua + ub) % MOD32;
                ovf = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
            end
            4'd1, 4'd2: begin
                r   = (ua + MOD32 - ub) % MOD32;
                ovf = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
            end
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = (ua * pw) % MOD32;
            4'd7: r = ua / pw;
            4'd8: begin
                // Arithmetic right shift is floor division by 2^shift.
                if (sa >= 0) sr = sa / longint'(pw);
                else         sr = -((-sa + longint'(pw) - 1) / longint'(pw));
                r = longint'(unsigned'(sr)) % MOD32;
            end
            default: r = 0;
        endcase
        e.res  = r[31:0];
        e.zero = (r == 0);
        e.ovf  = ovf;
        e.tag  = tag;
        return e;
    endfunction

    // Present one operation for the coming rising edge and record its expected response.
    task automatic drive(input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
        rst_n          = rst;
        bus.ULAControl = op;
        bus.scrA       = a;
        bus.scrB       = b;
        exp_q.push_back(model(rst, op, a, b, tag));
        @(negedge clk);
    endtask

    // Monitor: one registered response per edge; also confirm it holds across input changes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.tag, " result"}, bus.ULAResult, e.res);
                check({e.tag, " zero"}, {31'h0, bus.Zero}, {31'h0, e.zero});
`ifdef ULA32_OVF_EN
                check({e.tag, " ovf"}, {31'h0, bus.Overflow}, {31'h0, e.ovf});
`endif
                @(negedge clk);
                #2;
                check({e.tag, " hold"}, bus.ULAResult, e.res);
            end
        end
    end

    logic [31:0] sweep_a [3] = '{32'd3, 32'd4, 32'hC000_0004};
    logic [31:0] sweep_b [3] = '{32'd2, 32'd5, 32'd4};

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        int          waited;

        rst_n          = 1'b0;
        bus.ULAControl = 4'd0;
        bus.scrA       = 32'd0;
        bus.scrB       = 32'd0;

        drive(1'b0, 4'd0, 32'd0, 32'd0, "init");
        drive(1'b0, 4'd0, 32'd7, 32'd9, "init2");

        // Opcode sweeps 0000-1000 over the three operand pairs.
        for (int s = 0; s < 3; s++) begin
            for (int o = 0; o <= 8; o++) begin
                drive(1'b1, 4'(o), sweep_a[s], sweep_b[s], $sformatf("sweep%0d op%0d", s, o));
            end
        end

        // Shift-amount masking and undefined opcodes.
        drive(1'b1, 4'b0110, 32'd1, 32'h0000_0021, "mask sle");
        drive(1'b1, 4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, "mask sld");
        drive(1'b1, 4'b1000, 32'h8000_0000, 32'h0000_0020, "sad shift0");
        for (int o = 9; o <= 15; o++) begin
            drive(1'b1, 4'(o), 32'hDEAD_BEEF, 32'h1234_5678, $sformatf("undef op%0d", o));
        end

        // Reset in the middle of a stream, then release.
        drive(1'b1, 4'b0000, 32'd3, 32'd2, "pre-rst add");
        drive(1'b0, 4'b0000, 32'd3, 32'd2, "mid add");
        drive(1'b1, 4'b0000, 32'd3, 32'd2, "post-rst add");
        drive(1'b1, 4'b0001, 32'd10, 32'd4, "post-rst sub");

        // Overflow corners.
        drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'd1, "ovf add");
        drive(1'b1, 4'b0001, 32'h8000_0000, 32'd1, "ovf sub");
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf sub2");
        drive(1'b1, 4'b0011, 32'd3, 32'd2, "ovf and");
        drive(1'b1, 4'b0000, 32'h8000_0000, 32'h8000_0000, "ovf add neg");
        drive(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1, "add wrap");

        // Randomized traffic with occasional resets and edge-biased operands.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op > 4'd8 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 8));
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0000_0001;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom();
            endcase
            if (op == 4'd5 && $urandom_range(0, 3) == 0) b = a;
            r = ($urandom_range(0, 24) != 0);
            drive(r, op, a, b, $sformatf("rnd%0d op%0d", i, op));
        end

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
